// File: rtl/pu_ctrl_if.sv
// pu_ctrl_if: bundle of the run-control, operand-memory, pu and result-sink
// signals of one pu_ctrl instance.
//   start/busy/done          : run request and status towards layer control
//   op_addr/pu_en/pu_out     : operand-memory address, pu enable and pu result
//   res_valid/res_ready/     : result handshake towards the sink
//   res_addr/res_data
// Modports:
//   master : the controller side (pu_ctrl)
//   slave  : the environment side (layer control, memory, pu, sink)
interface pu_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] op_addr;
    logic              pu_en;
    logic [31:0]       pu_out;
    logic              res_valid;
    logic              res_ready;
    logic [ADDR_W-1:0] res_addr;
    logic [31:0]       res_data;

    modport master (
        input  start, pu_out, res_ready,
        output busy, done, op_addr, pu_en, res_valid, res_addr, res_data
    );

    modport slave (
        output start, pu_out, res_ready,
        input  busy, done, op_addr, pu_en, res_valid, res_addr, res_data
    );
endinterface

// File: rtl/pu_ctrl.sv
// pu_ctrl: sequencer for one pu instance. On start it issues NEURONS operand
// sets, one per cycle, and returns each activated pu result to a sink over a
// valid/ready handshake, stalling the pu while the sink back-pressures.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset, clears all state
//   bus        : pu_ctrl_if.master (start/busy/done, op_addr/pu_en/pu_out,
//                res_valid/res_ready/res_addr/res_data)
//   perf_stall : 16-bit saturating stall counter (only with PU_CTRL_PERF_EN)
// Optional feature macro: PU_CTRL_PERF_EN adds the perf_stall counter/port.
module pu_ctrl #(
    parameter int NEURONS = 4,
    parameter int ADDR_W  = 4
) (
    input  logic         clk,
    input  logic         rst,
    pu_ctrl_if.master    bus
`ifdef PU_CTRL_PERF_EN
    ,
    output logic [15:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURONS - 1);

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] res_addr_r;
    logic              res_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              pu_en_s;
    logic              issue_s;
    logic              start_acc_s;
    logic              hshake_s;

    assign hshake_s = res_valid_r && bus.res_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode plus issue/enable generation.
    always_comb begin
        state_nx_s  = state_r;
        pu_en_s     = 1'b0;
        issue_s     = 1'b0;
        start_acc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    start_acc_s = 1'b1;
                    state_nx_s  = ST_RUN;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Issue whenever the result slot is free or being emptied
                // this cycle; otherwise the pu register must hold.
                pu_en_s = !res_valid_r || bus.res_ready;
                issue_s = pu_en_s;
                if (issue_s && (idx_r == LAST_IDX)) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (hshake_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Operand index, result slot and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r       <= {ADDR_W{1'b0}};
            res_addr_r  <= {ADDR_W{1'b0}};
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // idx stops at the last index so NEURONS = 2^ADDR_W never wraps.
            if (start_acc_s) begin
                idx_r <= {ADDR_W{1'b0}};
            end else if (issue_s && (idx_r != LAST_IDX)) begin
                idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end

            // An issue refills the slot even when it is emptied this cycle,
            // giving back-to-back results.
            if (issue_s) begin
                res_valid_r <= 1'b1;
                res_addr_r  <= idx_r;
            end else if (hshake_s) begin
                res_valid_r <= 1'b0;
                res_addr_r  <= res_addr_r;
            end else begin
                res_valid_r <= res_valid_r;
                res_addr_r  <= res_addr_r;
            end

            busy_r <= (state_nx_s != ST_IDLE);
            done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.op_addr   = idx_r;
    assign bus.pu_en     = pu_en_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_addr  = res_addr_r;
    assign bus.res_data  = bus.pu_out;

`ifdef PU_CTRL_PERF_EN
    logic [15:0] perf_r;

    // Saturating count of cycles the sink holds off a pending result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_r <= 16'd0;
        end else if (start_acc_s) begin
            perf_r <= 16'd0;
        end else if (((state_r == ST_RUN) || (state_r == ST_DRAIN)) &&
                     res_valid_r && !bus.res_ready && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'd1;
        end else begin
            perf_r <= perf_r;
        end
    end

    assign perf_stall = perf_r;
`endif

endmodule

// File: tb/tb_pu_ctrl.sv
// tb_pu_ctrl: directed self-checking bench for pu_ctrl. Three instances
// (NEURONS = 4, 1, 16) each drive a small pu stand-in whose register loads
// op_addr + 10 while pu_en is high.
module tb_pu_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pu_ctrl_if #(.ADDR_W(4)) if4 ();
    pu_ctrl_if #(.ADDR_W(4)) if1 ();
    pu_ctrl_if #(.ADDR_W(4)) if16 ();

    logic [31:0] pu4  = 32'd0;
    logic [31:0] pu1  = 32'd0;
    logic [31:0] pu16 = 32'd0;

`ifdef PU_CTRL_PERF_EN
    logic [15:0] perf4;
    logic [15:0] perf1;
    logic [15:0] perf16;
    pu_ctrl #(.NEURONS(4),  .ADDR_W(4)) u4  (.clk(clk), .rst(rst), .bus(if4),  .perf_stall(perf4));
    pu_ctrl #(.NEURONS(1),  .ADDR_W(4)) u1  (.clk(clk), .rst(rst), .bus(if1),  .perf_stall(perf1));
    pu_ctrl #(.NEURONS(16), .ADDR_W(4)) u16 (.clk(clk), .rst(rst), .bus(if16), .perf_stall(perf16));
`else
    pu_ctrl #(.NEURONS(4),  .ADDR_W(4)) u4  (.clk(clk), .rst(rst), .bus(if4));
    pu_ctrl #(.NEURONS(1),  .ADDR_W(4)) u1  (.clk(clk), .rst(rst), .bus(if1));
    pu_ctrl #(.NEURONS(16), .ADDR_W(4)) u16 (.clk(clk), .rst(rst), .bus(if16));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pu product registers: not reset by the controller.
    always @(posedge clk) begin
        if (if4.pu_en)  pu4  <= {28'd0, if4.op_addr} + 32'd10;
        if (if1.pu_en)  pu1  <= {28'd0, if1.op_addr} + 32'd10;
        if (if16.pu_en) pu16 <= {28'd0, if16.op_addr} + 32'd10;
    end
    assign if4.pu_out  = pu4;
    assign if1.pu_out  = pu1;
    assign if16.pu_out = pu16;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if4.start = (i % 2 == 0) ? 1'b1 : 1'b0;
            #1;
            checks++;
            if ({if4.busy, if4.done, if4.pu_en, if4.res_valid} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags cyc %0d got %b exp 0000", i,
                         {if4.busy, if4.done, if4.pu_en, if4.res_valid});
            end
            checks++;
            if ({if4.op_addr, if4.res_addr} !== 8'h00) begin
                errors++;
                $display("FAIL reset_addr cyc %0d got %h exp 00", i, {if4.op_addr, if4.res_addr});
            end
        end
        if4.start = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_full_rate();
        tick();                       // cycle 0
        if4.start = 1'b1;
        if4.res_ready = 1'b1;
        #1;
        checks++;
        if ({if4.busy, if4.pu_en} !== 2'b00) begin
            errors++; $display("FAIL full_c0 got %b exp 00", {if4.busy, if4.pu_en});
        end
        tick();                       // cycle 1
        if4.start = 1'b0;
        #1;
        checks++;
        if ({if4.busy, if4.pu_en, if4.res_valid} !== 3'b110 || if4.op_addr !== 4'd0) begin
            errors++;
            $display("FAIL full_c1 got flags %b op %0d exp 110 op 0",
                     {if4.busy, if4.pu_en, if4.res_valid}, if4.op_addr);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            #1;
            checks++;
            if (if4.res_valid !== 1'b1 || if4.res_addr !== 4'(c - 2) ||
                if4.res_data !== 32'(c + 8) || if4.done !== 1'b0) begin
                errors++;
                $display("FAIL full_res cyc %0d got v%b a%0d d%0d dn%b exp v1 a%0d d%0d dn0", c,
                         if4.res_valid, if4.res_addr, if4.res_data, if4.done, c - 2, c + 8);
            end
            checks++;
            if (if4.pu_en !== ((c < 5) ? 1'b1 : 1'b0) ||
                (c < 5 && if4.op_addr !== 4'(c - 1))) begin
                errors++;
                $display("FAIL full_issue cyc %0d got en%b op%0d", c, if4.pu_en, if4.op_addr);
            end
        end
        tick();                       // cycle 6
        #1;
        checks++;
        if ({if4.done, if4.busy, if4.res_valid} !== 3'b110) begin
            errors++;
            $display("FAIL full_done got %b exp 110", {if4.done, if4.busy, if4.res_valid});
        end
        tick();                       // cycle 7
        #1;
        checks++;
        if ({if4.done, if4.busy} !== 2'b00) begin
            errors++; $display("FAIL full_idle got %b exp 00", {if4.done, if4.busy});
        end
    endtask

    task automatic test_back_pressure();
        for (int c = 0; c <= 9; c++) begin
            tick();
            if4.start = (c == 0) ? 1'b1 : 1'b0;
            if4.res_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            if (c >= 3 && c <= 5) begin
                checks++;
                if (if4.pu_en !== 1'b0 || if4.res_valid !== 1'b1 ||
                    if4.res_addr !== 4'd1 || if4.res_data !== 32'd11) begin
                    errors++;
                    $display("FAIL bp_stall cyc %0d got en%b v%b a%0d d%0d exp en0 v1 a1 d11", c,
                             if4.pu_en, if4.res_valid, if4.res_addr, if4.res_data);
                end
            end
            if (c >= 6 && c <= 8) begin
                checks++;
                if (if4.res_valid !== 1'b1 || if4.res_addr !== 4'(c - 5) ||
                    if4.res_data !== 32'(c + 5)) begin
                    errors++;
                    $display("FAIL bp_res cyc %0d got a%0d d%0d exp a%0d d%0d", c,
                             if4.res_addr, if4.res_data, c - 5, c + 5);
                end
            end
            checks++;
            if (if4.done !== ((c == 9) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL bp_done cyc %0d got %b", c, if4.done);
            end
        end
`ifdef PU_CTRL_PERF_EN
        checks++;
        if (perf4 !== 16'd3) begin
            errors++; $display("FAIL bp_perf got %0d exp 3", perf4);
        end
`endif
        tick();
    endtask

    task automatic test_single();
        for (int c = 0; c <= 5; c++) begin
            tick();
            if1.start = (c == 0 || c == 2) ? 1'b1 : 1'b0;
            if1.res_ready = 1'b1;
            #1;
            case (c)
                1: begin
                    checks++;
                    if ({if1.busy, if1.pu_en, if1.res_valid} !== 3'b110 || if1.op_addr !== 4'd0) begin
                        errors++; $display("FAIL single_issue got %b", {if1.busy, if1.pu_en, if1.res_valid});
                    end
                end
                2: begin
                    checks++;
                    if (if1.res_valid !== 1'b1 || if1.res_addr !== 4'd0 ||
                        if1.res_data !== 32'd10 || if1.pu_en !== 1'b0) begin
                        errors++;
                        $display("FAIL single_res got v%b a%0d d%0d en%b exp v1 a0 d10 en0",
                                 if1.res_valid, if1.res_addr, if1.res_data, if1.pu_en);
                    end
                end
                3: begin
                    checks++;
                    if ({if1.done, if1.busy} !== 2'b11) begin
                        errors++; $display("FAIL single_done got %b exp 11", {if1.done, if1.busy});
                    end
                end
                4, 5: begin
                    checks++;
                    if ({if1.done, if1.busy, if1.pu_en, if1.res_valid} !== 4'b0000) begin
                        errors++;
                        $display("FAIL single_norequeue cyc %0d got %b exp 0000", c,
                                 {if1.done, if1.busy, if1.pu_en, if1.res_valid});
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c <= 3; c++) begin
            tick();
            if4.start = (c == 0) ? 1'b1 : 1'b0;
            if4.res_ready = 1'b1;
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({if4.busy, if4.done, if4.pu_en, if4.res_valid} !== 4'b0000 ||
            {if4.op_addr, if4.res_addr} !== 8'h00) begin
            errors++;
            $display("FAIL midrst got flags %b op %0d ra %0d exp 0000 0 0",
                     {if4.busy, if4.done, if4.pu_en, if4.res_valid}, if4.op_addr, if4.res_addr);
        end
        tick();
        rst = 1'b1;
        test_full_rate();
    endtask

    task automatic test_n16();
        int  hs;
        int  last;
        int  done_cyc;
        hs = 0;
        last = -1;
        done_cyc = -1;
        tick();
        if16.start = 1'b1;
        if16.res_ready = 1'b1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            tick();
            if16.start = 1'b0;
            #1;
            if (if16.res_valid === 1'b1 && if16.res_ready === 1'b1) begin
                checks++;
                if (if16.res_addr !== 4'(hs) || if16.res_data !== 32'(hs + 10)) begin
                    errors++;
                    $display("FAIL n16_res hs %0d got a%0d d%0d exp a%0d d%0d", hs,
                             if16.res_addr, if16.res_data, hs, hs + 10);
                end
                last = int'(if16.res_addr);
                hs++;
            end
            if (if16.done === 1'b1) done_cyc = c;
        end
        checks++;
        if (hs !== 16 || last !== 15) begin
            errors++; $display("FAIL n16_count got hs %0d last %0d exp 16 15", hs, last);
        end
        checks++;
        if (done_cyc !== 18) begin
            errors++; $display("FAIL n16_done got cyc %0d exp 18", done_cyc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        if4.start = 1'b0;  if4.res_ready = 1'b0;
        if1.start = 1'b0;  if1.res_ready = 1'b0;
        if16.start = 1'b0; if16.res_ready = 1'b0;
        test_reset();
        test_full_rate();
        test_back_pressure();
        test_single();
        test_reset_mid_run();
        test_n16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
